q5_divider: RTL and testbench
=============================

Q5_DIVIDER -- requirements
Module: q5_divider

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits and iteration count at 4.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
REQ-003 The block SHALL have these data and control ports:
- a  input  8  unsigned dividend
- b  input  8  unsigned divisor
- start  input  1  request a division; sampled on each rising edge
- q  output  8  quotient, registered
- r  output  8  remainder, registered
- busy  output  1  a division is in progress
- ready  output  1  q/r hold a completed result
- count  output  2  index of the current radix-4 iteration, 0..3

Function
REQ-004 The block SHALL perform unsigned restoring division in radix 4, producing 2 quotient bits per clock over 4 iterations.
REQ-005 Start acceptance: on an edge with start=1 and busy=0, the block SHALL latch a and b internally, clear the 10-bit partial remainder, and set count=0, busy=1 and ready=0.
REQ-006 Each edge with busy=1 SHALL perform one iteration:
- shift {partial remainder, dividend register} left by 2
- select the largest digit d in 0..3 with d*b <= partial remainder
- subtract d*b from the partial remainder
- insert d into the 2 LSBs of the quotient register
REQ-007 Trial products 2b and 3b SHALL be computed at 10-bit width; no intermediate value may overflow.
REQ-008 count SHALL read 0, 1, 2, 3 during the four busy cycles and increment on each iteration edge.
REQ-009 On the edge executing the iteration with count=3, the block SHALL:
- write q and r
- clear busy and set ready
- return count to 0
REQ-010 Latency SHALL be exactly 5 edges: acceptance edge E, results and ready=1 visible after edge E+4, busy high after edges E through E+3.
REQ-011 q and r SHALL hold their previous values while busy=1 and change only at completion.
REQ-012 ready SHALL remain high until the next accepted start, which clears it.
REQ-013 start while busy=1 SHALL be ignored, and a and b changes during busy SHALL NOT affect the result.
REQ-014 start held high continuously SHALL begin a new division on the first edge after completion where busy=0.
REQ-015 Division by zero (b=0 at acceptance) SHALL still take 4 iterations and yield q=8'hFF and r=a.
REQ-016 busy and ready SHALL never be high simultaneously.

Reset
REQ-017 While rst=1 at a rising edge, all of the following SHALL be 0: q, r, busy, ready, count, the internal registers.
REQ-018 rst SHALL take priority over start, including mid-operation; the aborted division SHALL produce no result.
REQ-019 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-020 With macro Q5_DIVZERO_FLAG_EN defined:
- an extra output div_zero (1 bit, registered) SHALL exist
- div_zero SHALL be set at completion when b was 0 at acceptance, else cleared
- div_zero SHALL be cleared by rst and by any accepted start
REQ-021 Without Q5_DIVZERO_FLAG_EN, the div_zero port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- a=14, b=3, start pulse -> busy for 4 cycles with count 0,1,2,3, then ready=1, q=4, r=2.
- a=255, b=1 -> q=255, r=0; then a=7, b=9 -> q=0, r=7.
- a=200, b=0 -> q=8'hFF, r=200; div_zero=1 when Q5_DIVZERO_FLAG_EN is defined.
- start=1 and new a/b applied during busy -> ignored; the result matches the original operands.
- rst asserted at count=2 -> all outputs 0 on the next edge; a subsequent a=100, b=7 -> q=14, r=2.
- start held high -> back-to-back divisions; busy low for exactly one cycle between them, with ready=1 in that cycle.

Source files
------------

// File: rtl/q5_divider.sv
// Radix-4 restoring divider: 8-bit unsigned a/b, two quotient bits per clock over four iterations.
// Optional registered div_zero output is enabled by defining Q5_DIVZERO_FLAG_EN.
module q5_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       start,
    output logic [7:0] q,
    output logic [7:0] r,
    output logic       busy,
    output logic       ready,
    output logic [1:0] count
`ifdef Q5_DIVZERO_FLAG_EN
    ,
    output logic       div_zero
`endif
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      state_q, state_d;
    logic [7:0]  dvd_q, dvd_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [9:0]  rem_q, rem_d;
    logic [7:0]  quo_q, quo_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  q_q, q_d;
    logic [7:0]  r_q, r_d;
    logic        rdy_q, rdy_d;
`ifdef Q5_DIVZERO_FLAG_EN
    logic        dz_q, dz_d;
`endif

    logic [9:0]  shifted;
    logic [9:0]  trial1, trial2, trial3;
    logic [9:0]  rem_nxt;
    logic [1:0]  digit;

    // The remainder never exceeds 255, so dropping the top two bits of the shift is lossless.
    assign shifted = 10'({rem_q, dvd_q[7:6]});
    assign trial1  = {2'b00, dvs_q};
    assign trial2  = {1'b0, dvs_q, 1'b0};
    assign trial3  = trial2 + trial1;

    always_comb begin
        digit   = 2'd0;
        rem_nxt = shifted;
        if (shifted >= trial3) begin
            digit   = 2'd3;
            rem_nxt = shifted - trial3;
        end else if (shifted >= trial2) begin
            digit   = 2'd2;
            rem_nxt = shifted - trial2;
        end else if (shifted >= trial1) begin
            digit   = 2'd1;
            rem_nxt = shifted - trial1;
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        rdy_d   = rdy_q;
`ifdef Q5_DIVZERO_FLAG_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    dvd_d   = a;
                    dvs_d   = b;
                    rem_d   = 10'd0;
                    quo_d   = 8'd0;
                    cnt_d   = 2'd0;
                    rdy_d   = 1'b0;
`ifdef Q5_DIVZERO_FLAG_EN
                    dz_d    = 1'b0;
`endif
                end
            end
            default: begin
                rem_d = rem_nxt;
                dvd_d = {dvd_q[5:0], 2'b00};
                quo_d = {quo_q[5:0], digit};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_IDLE;
                    q_d     = {quo_q[5:0], digit};
                    r_d     = rem_nxt[7:0];
                    rdy_d   = 1'b1;
                    cnt_d   = 2'd0;
`ifdef Q5_DIVZERO_FLAG_EN
                    dz_d    = (dvs_q == 8'd0);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= 8'd0;
            dvs_q   <= 8'd0;
            rem_q   <= 10'd0;
            quo_q   <= 8'd0;
            cnt_q   <= 2'd0;
            q_q     <= 8'd0;
            r_q     <= 8'd0;
            rdy_q   <= 1'b0;
`ifdef Q5_DIVZERO_FLAG_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            rdy_q   <= rdy_d;
`ifdef Q5_DIVZERO_FLAG_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign q     = q_q;
    assign r     = r_q;
    assign busy  = (state_q == S_BUSY);
    assign ready = rdy_q;
    assign count = cnt_q;
`ifdef Q5_DIVZERO_FLAG_EN
    assign div_zero = dz_q;
`endif

endmodule

// File: tb/tb_q5_divider.sv
// Self-checking bench for q5_divider: directed scenarios plus random operands against an arithmetic model.
module tb_q5_divider;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       start;
    logic [7:0] q;
    logic [7:0] r;
    logic       busy;
    logic       ready;
    logic [1:0] count;
`ifdef Q5_DIVZERO_FLAG_EN
    logic       div_zero;
`endif

    int vectors;
    int miscompares;
    logic [7:0] hold_q;
    logic [7:0] hold_r;

    q5_divider dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .start (start),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .ready (ready),
        .count (count)
`ifdef Q5_DIVZERO_FLAG_EN
        ,
        .div_zero (div_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_q(input logic [7:0] x, input logic [7:0] y);
        return (y == 8'd0) ? 8'hFF : 8'(x / y);
    endfunction

    function automatic logic [7:0] model_r(input logic [7:0] x, input logic [7:0] y);
        return (y == 8'd0) ? x : 8'(x % y);
    endfunction

    // Start one division at the next falling edge and check every busy cycle and the result.
    // noisy=1 keeps start high with scrambled operands throughout the busy window.
    task automatic run_div(input logic [7:0] ta, input logic [7:0] tb_v, input bit noisy);
        logic [7:0] eq, er;
        eq = model_q(ta, tb_v);
        er = model_r(ta, tb_v);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = noisy;
            a = 8'($urandom);
            b = 8'($urandom);
            chk("busy", 32'(busy), 32'd1);
            chk("ready_low", 32'(ready), 32'd0);
            chk("count", 32'(count), 32'(i));
            chk("q_hold", 32'(q), 32'(hold_q));
            chk("r_hold", 32'(r), 32'(hold_r));
`ifdef Q5_DIVZERO_FLAG_EN
            chk("dz_clear", 32'(div_zero), 32'd0);
`endif
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_ready", 32'(ready), 32'd1);
        chk("done_count", 32'(count), 32'd0);
        chk("q", 32'(q), 32'(eq));
        chk("r", 32'(r), 32'(er));
`ifdef Q5_DIVZERO_FLAG_EN
        chk("div_zero", 32'(div_zero), 32'(tb_v == 8'd0));
`endif
        hold_q = eq;
        hold_r = er;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q"}, 32'(q), 32'd0);
        chk({tag, "_r"}, 32'(r), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
`ifdef Q5_DIVZERO_FLAG_EN
        chk({tag, "_dz"}, 32'(div_zero), 32'd0);
`endif
    endtask

    initial begin
        logic [7:0] ra, rb;
        vectors = 0;
        miscompares = 0;
        hold_q = 8'd0;
        hold_r = 8'd0;
        rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        run_div(8'd14, 8'd3, 1'b0);
        run_div(8'd255, 8'd1, 1'b0);
        run_div(8'd7, 8'd9, 1'b0);
        run_div(8'd200, 8'd0, 1'b0);
        run_div(8'd50, 8'd6, 1'b1);

        // Abort mid-division with reset at count=2.
        @(negedge clk);
        a = 8'd90; b = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_count", 32'(count), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        rst = 1'b0;
        hold_q = 8'd0;
        hold_r = 8'd0;
        run_div(8'd100, 8'd7, 1'b0);

        // Start held high: back-to-back divisions separated by one idle ready cycle.
        @(negedge clk);
        a = 8'd123; b = 8'd10; start = 1'b1;
        repeat (4) @(negedge clk);
        chk("b2b_busy_last", 32'(busy), 32'd1);
        a = 8'd77; b = 8'd5;
        @(negedge clk);
        chk("b2b_gap_busy", 32'(busy), 32'd0);
        chk("b2b_gap_ready", 32'(ready), 32'd1);
        chk("b2b_q1", 32'(q), 32'(model_q(8'd123, 8'd10)));
        chk("b2b_r1", 32'(r), 32'(model_r(8'd123, 8'd10)));
        @(negedge clk);
        start = 1'b0;
        chk("b2b_restart_busy", 32'(busy), 32'd1);
        chk("b2b_restart_ready", 32'(ready), 32'd0);
        repeat (4) @(negedge clk);
        chk("b2b_q2", 32'(q), 32'(model_q(8'd77, 8'd5)));
        chk("b2b_r2", 32'(r), 32'(model_r(8'd77, 8'd5)));
        chk("b2b_ready2", 32'(ready), 32'd1);
        hold_q = model_q(8'd77, 8'd5);
        hold_r = model_r(8'd77, 8'd5);

        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_div(ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
